bus_arbiter: RTL

- Shares the single system bus between up to NUM_MASTERS bus masters: the IF bus interface, the MEM bus interface and future DMA/debug masters.
- Each master requests with an active-low Req_ and may drive the bus only while its active-low Grnt_ is asserted.
- Uses round-robin fairness and never revokes a grant mid-transfer.
- An optional hold limit preempts a master that hogs the bus while others wait.

---
 rtl/bus_arbiter_pkg.sv | 14 +
 rtl/bus_arbiter_if.sv | 25 ++
 rtl/bus_arbiter_rr_pick.sv | 39 +++
 rtl/bus_arbiter.sv | 107 ++++++++++
 4 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared types and defaults for the system bus arbiter and its request picker.
package bus_arbiter_pkg;

    localparam int DEF_NUM_MASTERS = 4;
    localparam int DEF_OWNER_W     = 2;
    localparam int DEF_MAX_HOLD    = 16;
    localparam int DEF_HOLD_W      = 5;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_OWN  = 1'b1
    } arb_state_e;

endpackage

// File: rtl/bus_arbiter_if.sv
// Arbitration bus: per-master request/grant plus the owner's transfer status.
interface bus_arbiter_if
    import bus_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS = DEF_NUM_MASTERS,
    parameter int OWNER_W     = DEF_OWNER_W
);
    logic [NUM_MASTERS-1:0] MReq_;
    logic [NUM_MASTERS-1:0] MGrnt_;
    logic                   BusAs_;
    logic                   BusRdy_;
    logic [OWNER_W-1:0]     Owner;
    logic                   Granted;

    // master: the requesting bus units; slave: the arbiter serving them
    modport master (
        output MReq_, BusAs_, BusRdy_,
        input  MGrnt_, Owner, Granted
    );

    modport slave (
        input  MReq_, BusAs_, BusRdy_,
        output MGrnt_, Owner, Granted
    );
endinterface

// File: rtl/bus_arbiter_rr_pick.sv
// Round-robin picker: rotate requests to start after the last owner,
// priority-encode the lowest set bit, rotate the index back.
module rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last,
    output logic [W-1:0] winner,
    output logic         valid
);

    logic [N-1:0] rot;
    logic [W:0]   start;
    logic [W:0]   off;
    logic [W:0]   sum;

    // NOTE: every variable assigned here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        start = {1'b0, last} + (W+1)'(1);
        rot   = '0;
        off   = '0;
        sum   = '0;
        for (int j = 0; j < N; j++) begin
            sum = start + (W+1)'(j);
            if (sum >= (W+1)'(N)) sum = sum - (W+1)'(N);
            rot[j] = req[sum[W-1:0]];
        end
        for (int j = N - 1; j >= 0; j--) begin
            if (rot[j]) off = (W+1)'(j);
        end
        sum = start + off;
        if (sum >= (W+1)'(N)) sum = sum - (W+1)'(N);
        winner = sum[W-1:0];
        valid  = |rot;
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin system bus arbiter with registered grants, a forced idle cycle
// on every handover, and optional preemption of a master hogging the bus.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS = DEF_NUM_MASTERS,
    parameter int OWNER_W     = DEF_OWNER_W,
    parameter int MAX_HOLD    = DEF_MAX_HOLD,
    parameter int HOLD_W      = DEF_HOLD_W
) (
    input  logic          clk,
    input  logic          reset_,
    bus_arbiter_if.slave  bus
);

    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

    arb_state_e             state_q, state_d;
    logic [OWNER_W-1:0]     owner_q, owner_d;
    logic [HOLD_W-1:0]      hold_q, hold_d;
    logic [NUM_MASTERS-1:0] mgrnt_q, mgrnt_d;
    logic                   granted_q, granted_d;

    logic [NUM_MASTERS-1:0] req;
    logic [NUM_MASTERS-1:0] others;
    logic [OWNER_W-1:0]     pick_winner;
    logic                   pick_valid;
    logic                   boundary;
    logic                   preempt;

    assign req = ~bus.MReq_;

    rr_pick #(
        .N (NUM_MASTERS),
        .W (OWNER_W)
    ) u_rr_pick (
        .req    (req),
        .last   (owner_q),
        .winner (pick_winner),
        .valid  (pick_valid)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values; the async reset drops grants with no clock.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q   <= ARB_IDLE;
            owner_q   <= OWNER_W'(NUM_MASTERS - 1);
            hold_q    <= '0;
            mgrnt_q   <= '1;
            granted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            hold_q    <= hold_d;
            mgrnt_q   <= mgrnt_d;
            granted_q <= granted_d;
        end
    end

    // A transfer boundary is an idle bus or an access completing this cycle.
    always_comb begin
        others          = req;
        others[owner_q] = 1'b0;
        boundary        = bus.BusAs_ || !bus.BusRdy_;
        preempt         = (MAX_HOLD != 0) && (hold_q == HOLD_MAX) &&
                          (|others) && boundary;
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        hold_d  = hold_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    state_d = ARB_OWN;
                    owner_d = pick_winner;
                    hold_d  = '0;
                end
            end
            ARB_OWN: begin
                if (!req[owner_q] || preempt) begin
                    state_d = ARB_IDLE;
                end else if (hold_q != HOLD_MAX) begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and then registered.
    always_comb begin
        mgrnt_d   = '1;
        granted_d = 1'b0;
        if (state_d == ARB_OWN) begin
            mgrnt_d[owner_d] = 1'b0;
            granted_d        = 1'b1;
        end
    end

    assign bus.MGrnt_  = mgrnt_q;
    assign bus.Owner   = owner_q;
    assign bus.Granted = granted_q;

endmodule
